// File: rtl/mpc_cstr_pkg.sv
// rtl/mpc_cstr_pkg.sv - shared modes, states and defaults for the constraint vector copy
package mpc_cstr_pkg;

    localparam int W_DEF = 21;

    typedef enum logic [1:0] {
        MODE_COPY = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_BIAS = 2'b10,
        MODE_BOX  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR_P = 3'd2,
        S_WR_N = 3'd3,
        S_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mpc_constraint_vec_copy_if.sv
// rtl/mpc_constraint_vec_copy_if.sv - block handshake plus source and destination RAM ports
interface mpc_constraint_vec_copy_if #(
    parameter int W      = 21,
    parameter int SRC_AW = 3,
    parameter int DST_AW = 5
);
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [SRC_AW-1:0] src_address0;
    logic              src_ce0;
    logic [W-1:0]      src_q0;
    logic [DST_AW-1:0] h_address0;
    logic              h_ce0;
    logic              h_we0;
    logic [W-1:0]      h_d0;

    modport master (
        input  ap_start,
        output ap_done, ap_idle, ap_ready,
        output src_address0, src_ce0,
        input  src_q0,
        output h_address0, h_ce0, h_we0, h_d0
    );

    modport slave (
        output ap_start,
        input  ap_done, ap_idle, ap_ready,
        input  src_address0, src_ce0,
        output src_q0,
        input  h_address0, h_ce0, h_we0, h_d0
    );
endinterface

// File: rtl/mpc_sat_sub.sv
// rtl/mpc_sat_sub.sv - W-bit signed a-b with clamp to the representable range
module mpc_sat_sub #(
    parameter int W = 21
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic [W:0] diff;

    assign diff = {a_i[W-1], a_i} - {b_i[W-1], b_i};

    // Overflow shows as the two top bits of the W+1-bit difference disagreeing.
    always_comb begin
        y_o = diff[W-1:0];
        if (diff[W] != diff[W-1]) begin
            y_o = diff[W] ? MIN_V : MAX_V;
        end
    end
endmodule

// File: rtl/mpc_constraint_vec_copy.sv
// rtl/mpc_constraint_vec_copy.sv - copies L source words into h at a base offset with optional transform
module mpc_constraint_vec_copy
    import mpc_cstr_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int SRC_AW = 3,
    parameter int DST_AW = 5,
    parameter int LEN_W  = 4
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    mpc_constraint_vec_copy_if.master bus,
    input  logic [LEN_W-1:0]         len,
    input  logic [DST_AW-1:0]        dst_base,
    input  logic [1:0]               mode,
    input  logic [W-1:0]             bias
);
    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DST_AW-1:0]  base_q, base_d;
    mode_t              mode_q, mode_d;
    logic [W-1:0]       bias_q, bias_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       hold_q, hold_d;

    logic               ready, done, idle;
    logic [SRC_AW-1:0]  src_addr;
    logic               src_ce;
    logic [DST_AW-1:0]  h_addr;
    logic               h_ce;
    logic [W-1:0]       h_d;

    logic [W-1:0]       sat_a, sat_b, sat_y, fval;
    logic [DST_AW-1:0]  wr_off;
    logic               last_rd, more_rd;

    // idx_q counts issued reads, so the word in flight belongs to element idx_q-1.
    assign wr_off  = DST_AW'(idx_q) - DST_AW'(1);
    assign last_rd = ((LEN_W+1)'(idx_q) + (LEN_W+1)'(1)) == (LEN_W+1)'(len_q);
    assign more_rd = idx_q < len_q;

    // One subtractor serves both 0-x and bias-x; in the box negative phase x is the held word.
    assign sat_a = (mode_q == MODE_BIAS) ? bias_q : '0;
    assign sat_b = (state_q == S_WR_N) ? hold_q : bus.src_q0;
    assign fval  = (mode_q == MODE_COPY || mode_q == MODE_BOX) ? bus.src_q0 : sat_y;

    mpc_sat_sub #(.W(W)) u_sat (
        .a_i (sat_a),
        .b_i (sat_b),
        .y_o (sat_y)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            base_q  <= '0;
            mode_q  <= MODE_COPY;
            bias_q  <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            bias_q  <= bias_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        base_d   = base_q;
        mode_d   = mode_q;
        bias_d   = bias_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        ready    = 1'b0;
        done     = 1'b0;
        idle     = 1'b0;
        src_addr = '0;
        src_ce   = 1'b0;
        h_addr   = '0;
        h_ce     = 1'b0;
        h_d      = '0;

        case (state_q)
            S_IDLE: begin
                idle = 1'b1;
                if (bus.ap_start) begin
                    ready   = 1'b1;
                    len_d   = len;
                    base_d  = dst_base;
                    mode_d  = mode_t'(mode);
                    bias_d  = bias;
                    idx_d   = '0;
                    state_d = (len == '0) ? S_FIN : S_RD;
                end
            end
            S_RD: begin
                src_ce   = 1'b1;
                src_addr = SRC_AW'(idx_q);
                idx_d    = idx_q + LEN_W'(1);
                if (mode_q == MODE_BOX) begin
                    state_d = S_WR_P;
                end else begin
                    if (idx_q != '0) begin
                        h_ce   = 1'b1;
                        h_addr = base_q + wr_off;
                        h_d    = fval;
                    end
                    if (last_rd) begin
                        state_d = S_WR_P;
                    end
                end
            end
            S_WR_P: begin
                h_ce   = 1'b1;
                h_addr = base_q + wr_off;
                h_d    = fval;
                if (mode_q == MODE_BOX) begin
                    hold_d  = bus.src_q0;
                    state_d = S_WR_N;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_WR_N: begin
                h_ce   = 1'b1;
                h_addr = base_q + DST_AW'(len_q) + wr_off;
                h_d    = sat_y;
                if (more_rd) begin
                    src_ce   = 1'b1;
                    src_addr = SRC_AW'(idx_q);
                    idx_d    = idx_q + LEN_W'(1);
                    state_d  = S_WR_P;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset takes effect on strobes in the very cycle it is raised.
        if (ap_rst) begin
            ready    = 1'b0;
            done     = 1'b0;
            src_ce   = 1'b0;
            src_addr = '0;
            h_ce     = 1'b0;
            h_addr   = '0;
            h_d      = '0;
        end
    end

    assign bus.ap_ready     = ready;
    assign bus.ap_done      = done;
    assign bus.ap_idle      = idle;
    assign bus.src_address0 = src_addr;
    assign bus.src_ce0      = src_ce;
    assign bus.h_address0   = h_addr;
    assign bus.h_ce0        = h_ce;
    assign bus.h_we0        = h_ce;
    assign bus.h_d0         = h_d;
endmodule

// File: tb/tb_mpc_constraint_vec_copy.sv
// tb/tb_mpc_constraint_vec_copy.sv - randomized self-checking bench against a behavioural copy model
module tb_mpc_constraint_vec_copy;
    localparam int W      = 21;
    localparam int SRC_AW = 3;
    localparam int DST_AW = 5;
    localparam int LEN_W  = 4;
    localparam int HN     = 1 << DST_AW;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic [LEN_W-1:0]  len = '0;
    logic [DST_AW-1:0] dst_base = '0;
    logic [1:0]        mode = '0;
    logic [W-1:0]      bias = '0;

    always #5 ap_clk = ~ap_clk;

    mpc_constraint_vec_copy_if #(.W(W), .SRC_AW(SRC_AW), .DST_AW(DST_AW)) bus ();

    mpc_constraint_vec_copy #(.W(W), .SRC_AW(SRC_AW), .DST_AW(DST_AW), .LEN_W(LEN_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .bus      (bus),
        .len      (len),
        .dst_base (dst_base),
        .mode     (mode),
        .bias     (bias)
    );

    logic [W-1:0] src_mem [8];
    longint       fv      [8];
    longint       h_mem   [HN];
    longint       exp_mem [HN];
    int           n_chk = 0;
    int           n_fail = 0;

    always @(posedge ap_clk) begin
        if (bus.src_ce0) bus.src_q0 <= src_mem[bus.src_address0];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        logic signed [W-1:0] s;
        s = v;
        return longint'(s);
    endfunction

    function automatic longint sat(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (W-1)) - 1;
        lo = -(longint'(1) <<< (W-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint rnd_word();
        int r;
        r = int'($urandom_range(0, 5));
        if (r == 0) return -(longint'(1) <<< (W-1));
        if (r == 1) return (longint'(1) <<< (W-1)) - 1;
        return sx(W'($urandom));
    endfunction

    task automatic load_src();
        for (int i = 0; i < 8; i++) begin
            logic [63:0] t;
            t = fv[i];
            src_mem[i] = t[W-1:0];
        end
    endtask

    task automatic compare_mem(input string name);
        for (int a = 0; a < HN; a++) chk($sformatf("%s h[%0d]", name, a), h_mem[a], exp_mem[a]);
    endtask

    // One complete run: model the expected RAM image and timing, then drive and observe the DUT.
    task automatic run(input string name, input int L, input int b, input int md, input longint bv, input bit poke);
        int exp_done, exp_nw, done_c, nw, first_w, last_w, bad_cewe, bad_rdy;
        logic [63:0] bt;
        exp_mem = h_mem;
        for (int i = 0; i < L; i++) begin
            case (md)
                0: exp_mem[(b + i) % HN] = fv[i];
                1: exp_mem[(b + i) % HN] = sat(-fv[i]);
                2: exp_mem[(b + i) % HN] = sat(bv - fv[i]);
                default: begin
                    exp_mem[(b + i) % HN]     = fv[i];
                    exp_mem[(b + L + i) % HN] = sat(-fv[i]);
                end
            endcase
        end
        exp_done = (L == 0) ? 1 : (md == 3) ? 2 * L + 2 : L + 2;
        exp_nw   = (md == 3) ? 2 * L : L;
        load_src();

        done_c = -1; nw = 0; first_w = -1; last_w = -1; bad_cewe = 0; bad_rdy = 0;
        bt = bv;
        @(negedge ap_clk);
        len = LEN_W'(L); dst_base = DST_AW'(b); mode = 2'(md); bias = bt[W-1:0];
        bus.ap_start = 1'b1;
        #1;
        chk({name, " ready_c0"}, longint'(bus.ap_ready), 1);
        for (int c = 1; c <= 60; c++) begin
            @(negedge ap_clk);
            bus.ap_start = poke && (c == 3);
            len = LEN_W'($urandom); dst_base = DST_AW'($urandom);
            mode = 2'($urandom); bias = W'($urandom);
            #1;
            if (bus.h_ce0 != bus.h_we0) bad_cewe++;
            if (bus.ap_ready) bad_rdy++;
            if (bus.h_we0) begin
                h_mem[bus.h_address0] = sx(bus.h_d0);
                nw++;
                if (first_w < 0) first_w = c;
                last_w = c;
            end
            if (bus.ap_done) begin
                done_c = c;
                break;
            end
        end
        bus.ap_start = 1'b0;
        chk({name, " done_cycle"}, done_c, exp_done);
        chk({name, " writes"}, nw, exp_nw);
        chk({name, " ready_late"}, bad_rdy, 0);
        chk({name, " ce_we"}, bad_cewe, 0);
        if (L > 0) begin
            chk({name, " first_wr"}, first_w, 2);
            chk({name, " last_wr"}, last_w, exp_done - 1);
        end
        compare_mem(name);
        @(negedge ap_clk);
        #1;
        chk({name, " idle_after"}, longint'(bus.ap_idle), 1);
    endtask

    initial begin
        bus.ap_start = 1'b0;
        bus.src_q0   = '0;
        for (int a = 0; a < HN; a++) h_mem[a] = 0;
        for (int i = 0; i < 8; i++) fv[i] = 0;
        load_src();

        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        #1;
        chk("rst idle", longint'(bus.ap_idle), 1);
        chk("rst done", longint'(bus.ap_done), 0);
        chk("rst ready", longint'(bus.ap_ready), 0);
        chk("rst src_ce", longint'(bus.src_ce0), 0);
        chk("rst h_we", longint'(bus.h_we0), 0);
        chk("rst h_addr", longint'(bus.h_address0), 0);
        chk("rst h_d", longint'(bus.h_d0), 0);

        for (int i = 0; i < 6; i++) fv[i] = i + 1;
        run("copy6", 6, 0, 0, 0, 1'b1);

        fv[0] = 5; fv[1] = -1; fv[2] = -(longint'(1) <<< 20);
        run("neg3", 3, 10, 1, 0, 1'b0);

        fv[0] = -3; fv[1] = 7;
        run("bias2", 2, 4, 2, (longint'(1) <<< 20) - 1, 1'b0);

        fv[0] = 2; fv[1] = 3; fv[2] = 4;
        run("box3", 3, 30, 3, 0, 1'b0);

        run("len0", 0, 7, 0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 8; i++) fv[i] = rnd_word();
            run($sformatf("rnd%0d", r), int'($urandom_range(0, 8)), int'($urandom_range(0, HN - 1)),
                int'($urandom_range(0, 3)), rnd_word(), 1'($urandom));
        end

        // Start held through FIN: next accept lands in the first idle cycle.
        @(negedge ap_clk);
        len = '0; dst_base = '0; mode = '0; bus.ap_start = 1'b1;
        #1 chk("b2b ready_c0", longint'(bus.ap_ready), 1);
        @(negedge ap_clk);
        #1 chk("b2b done_c1", longint'(bus.ap_done), 1);
        chk("b2b ready_c1", longint'(bus.ap_ready), 0);
        @(negedge ap_clk);
        #1 chk("b2b ready_c2", longint'(bus.ap_ready), 1);
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        #1 chk("b2b done_c3", longint'(bus.ap_done), 1);
        @(negedge ap_clk);
        #1 chk("b2b idle_c4", longint'(bus.ap_idle), 1);

        // Reset raised in cycle 3 of an L=6 copy: only the cycle-2 write survives.
        begin
            int late_w, late_d;
            for (int i = 0; i < 6; i++) fv[i] = 100 + i;
            load_src();
            exp_mem = h_mem;
            exp_mem[0] = fv[0];
            late_w = 0; late_d = 0;
            @(negedge ap_clk);
            len = 4'd6; dst_base = '0; mode = 2'b00; bus.ap_start = 1'b1;
            #1 chk("rst_run ready_c0", longint'(bus.ap_ready), 1);
            for (int c = 1; c <= 14; c++) begin
                @(negedge ap_clk);
                bus.ap_start = 1'b0;
                ap_rst = (c == 3);
                #1;
                if (c == 4) chk("rst_run idle_c4", longint'(bus.ap_idle), 1);
                if (bus.h_we0) begin
                    h_mem[bus.h_address0] = sx(bus.h_d0);
                    if (c >= 3) late_w++;
                end
                if (bus.ap_done) late_d++;
            end
            chk("rst_run late_writes", late_w, 0);
            chk("rst_run done", late_d, 0);
            compare_mem("rst_run");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mpc_constraint_vec_copy.md
Name: mpc_constraint_vec_copy

Overview:
Parametrised successor of the fixed 6-element constraint-copy loop in the dense-constraint stage of the MPC solver. It reads L words from a source vector RAM (f1_V-style, 1-cycle read latency) and writes them into the constraint RHS RAM h at a run-time base offset. A mode selects plain copy, saturated negation, saturated bias-minus-value, or a two-sided box write (h[b+i]=f[i], h[b+L+i]=-f[i]). Control uses the ap_start/ap_done/ap_idle/ap_ready block-level handshake.

Parameters:
W, 21, data word width (signed fixed point, two's complement)
SRC_AW, 3, source RAM address width
DST_AW, 5, destination RAM address width
LEN_W, 4, width of the run-time length input

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset; synchronous, active-high
ap_start  in  1  start request
ap_done  out  1  one-cycle completion pulse
ap_idle  out  1  high while in IDLE
ap_ready  out  1  one-cycle pulse when a start is accepted
len  in  LEN_W  element count L; sampled at accept
dst_base  in  DST_AW  destination base offset b; sampled at accept
mode  in  2  00 copy, 01 negate, 10 bias-minus, 11 box; sampled at accept
bias  in  W  bias operand for mode 10; sampled at accept
src_address0  out  SRC_AW  source read address
src_ce0  out  1  source read enable
src_q0  in  W  source read data, valid the cycle after src_ce0
h_address0  out  DST_AW  destination address
h_ce0  out  1  destination enable
h_we0  out  1  destination write enable
h_d0  out  W  destination write data

Behaviour:
- Reset: state IDLE; ap_done=0, ap_ready=0, ap_idle=1; src_ce0, h_ce0, h_we0 = 0; address/data outputs 0. Reset mid-run aborts immediately: no further RAM strobes, no ap_done.
- States: IDLE, RD, WR_P, WR_N, FIN.
- IDLE: ap_start=1 in cycle 0 -> ap_ready=1 in cycle 0, latch len/dst_base/mode/bias, index i=0. If L=0 go FIN, else go RD.
- Modes 00/01/10 (II=1, pipelined): cycle k (k=1..L) asserts src_ce0, src_address0=k-1; cycle k+1 asserts h_ce0=h_we0=1, h_address0=b+k-1, h_d0=f(src_q0). Last write in cycle L+1; ap_done pulses in cycle L+2 (FIN); IDLE in cycle L+3.
- Mode 11 (II=2, single destination port): read f[i] in cycle 1+2i; write h[b+i]=f[i] in cycle 2+2i (data held in a register); write h[b+L+i]=sat(-f[i]) in cycle 3+2i, overlapped with the read of f[i+1]. Last write in cycle 2L+1; ap_done in cycle 2L+2.
- f(x): 00 -> x; 01 -> sat(-x); 10 -> sat(bias - x), computed in W+1 bits then clamped.
- sat: clamp to [-2^(W-1), 2^(W-1)-1]; -(-2^(W-1)) yields 2^(W-1)-1.
- Destination address arithmetic is modulo 2^DST_AW (wraps, no error). Source addresses L-1 >= 2^SRC_AW are the caller's error; the low SRC_AW bits are used.
- ap_start while not IDLE is ignored; ap_ready stays 0. Start inputs may change freely after accept.
- ap_start held high across FIN -> new accept in the first IDLE cycle (back-to-back runs, one idle cycle between).
- h_ce0=h_we0 always; the block never reads h.

Decomposition:
- Shared package mpc_cstr_pkg: mode encodings (MODE_COPY, MODE_NEG, MODE_BIAS, MODE_BOX), state enum, default W.
- One sub-module: mpc_sat_sub (W-bit saturated a-b, used as 0-x and bias-x), combinational.

Test Plan:
- L=6, b=0, mode 00, f=[1..6] -> h[0..5]=[1..6]; writes in cycles 2..7; ap_done in cycle 8; ap_ready only in cycle 0.
- L=3, b=10, mode 01, f=[5,-1,-2^20] -> h[10..12]=[-5,1,2^20-1] (saturated).
- L=2, b=4, mode 10, bias=2^20-1, f=[-3,7] -> h[4]=2^20-1 (clamped), h[5]=2^20-8.
- L=3, b=30, mode 11, f=[2,3,4] -> h[30]=2, h[31]=3, h[0]=4 (wrap), h[1]=-2, h[2]=-3, h[3]=-4; ap_done in cycle 8.
- L=0 -> no h_we0; ap_done in cycle 1. A second ap_start mid-run is ignored; ap_rst in cycle 3 of an L=6 run -> no writes after reset, ap_idle=1 the next cycle.
